// File: rtl/flt_vector_stream_gen.sv
// Streams floating-point operand pairs for FP core testing: IEEE special values first, then
// per-channel Galois LFSR patterns, with single-pass or looping runs and a pass counter.
module flt_vector_stream_gen #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MAN_W  = 23,
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned CNT_W  = 16,
    parameter logic [31:0] SEED_A = 32'h1215_3524,
    parameter logic [31:0] SEED_B = 32'h8937_5212,
    localparam int unsigned DATA_W = 1 + EXP_W + MAN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W:0]    vec_count,
    input  logic              loop_mode,
    input  logic              stop,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt
);

    localparam logic [31:0]    TAPS       = 32'h8020_0003;
    localparam logic [31:0]    SEED_A_EFF = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
    localparam logic [31:0]    SEED_B_EFF = (SEED_B == 32'd0) ? 32'd1 : SEED_B;
    localparam logic [IDX_W:0] MAX_CNT    = {1'b1, {IDX_W{1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q;
    logic [IDX_W:0] cnt_q;
    logic           loop_q;
    logic           stop_q;
    logic [31:0]    lfsr_a_q;
    logic [31:0]    lfsr_b_q;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {1'b0, l[31:1]} ^ (l[0] ? TAPS : 32'd0);
    endfunction

    function automatic logic [DATA_W-1:0] special(input logic [2:0] k);
        logic [DATA_W-1:0] v;
        case (k)
            3'd0:    v = '0;
            3'd1:    v = {1'b1, {(EXP_W + MAN_W){1'b0}}};
            3'd2:    v = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            3'd3:    v = {1'b1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            3'd4:    v = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
            3'd5:    v = {1'b0, {(EXP_W - 1){1'b0}}, 1'b1, {MAN_W{1'b0}}};
            3'd6:    v = {1'b0, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            default: v = {1'b0, {(EXP_W + MAN_W - 1){1'b0}}, 1'b1};
        endcase
        return v;
    endfunction

    logic [IDX_W:0]    cnt_clamp;
    logic [IDX_W:0]    nxt_cnt;
    logic              load;
    logic              stop_req;
    logic [IDX_W-1:0]  nxt_idx;
    logic [31:0]       nxt_idx32;
    logic [2:0]        sel_a;
    logic [2:0]        sel_b;
    logic [31:0]       nxt_lfsr_a;
    logic [31:0]       nxt_lfsr_b;
    logic              nxt_last;
    logic [DATA_W-1:0] nxt_a;
    logic [DATA_W-1:0] nxt_b;

    // Next vector to present: vector 0 of a fresh pass on start or wrap, otherwise idx+1.
    always_comb begin
        cnt_clamp = (vec_count > MAX_CNT) ? MAX_CNT : vec_count;
        nxt_cnt   = (state_q == StIdle) ? cnt_clamp : cnt_q;
        load      = (state_q == StIdle) || out_last;
        stop_req  = stop_q | stop;
        nxt_idx   = load ? '0 : out_idx + 1'b1;
        nxt_last  = ({1'b0, nxt_idx} == nxt_cnt - 1'b1);
        nxt_lfsr_a = lfsr_a_q;
        nxt_lfsr_b = lfsr_b_q;
        // LFSRs only advance when a random vector (idx >= 8) is consumed.
        if (32'(out_idx) >= 32'd8) begin
            nxt_lfsr_a = lfsr_step(lfsr_a_q);
            nxt_lfsr_b = lfsr_step(lfsr_b_q);
        end
        if (load) begin
            nxt_lfsr_a = SEED_A_EFF;
            nxt_lfsr_b = SEED_B_EFF;
        end
        nxt_idx32 = 32'(nxt_idx);
        sel_a     = nxt_idx32[2:0];
        sel_b     = sel_a + 3'd3;
        if (nxt_idx32 < 32'd8) begin
            nxt_a = special(sel_a);
            nxt_b = special(sel_b);
        end else begin
            nxt_a = nxt_lfsr_a[DATA_W-1:0];
            nxt_b = nxt_lfsr_b[DATA_W-1:0];
        end
    end

    assign busy = (state_q == StRun);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            loop_q    <= 1'b0;
            stop_q    <= 1'b0;
            lfsr_a_q  <= '0;
            lfsr_b_q  <= '0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            pass_cnt  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        pass_cnt <= '0;
                        stop_q   <= 1'b0;
                        if (vec_count != '0) begin
                            state_q   <= StRun;
                            cnt_q     <= cnt_clamp;
                            loop_q    <= loop_mode;
                            lfsr_a_q  <= nxt_lfsr_a;
                            lfsr_b_q  <= nxt_lfsr_b;
                            out_valid <= 1'b1;
                            out_a     <= nxt_a;
                            out_b     <= nxt_b;
                            out_idx   <= nxt_idx;
                            out_last  <= nxt_last;
                        end else begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                        if (stop_req || (out_last && !loop_q)) begin
                            state_q   <= StDone;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            stop_q    <= 1'b0;
                        end else begin
                            lfsr_a_q <= nxt_lfsr_a;
                            lfsr_b_q <= nxt_lfsr_b;
                            out_a    <= nxt_a;
                            out_b    <= nxt_b;
                            out_idx  <= nxt_idx;
                            out_last <= nxt_last;
                        end
                    end else begin
                        stop_q <= stop_req;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_flt_vector_stream_gen.sv
// Self-checking bench for flt_vector_stream_gen: table of runs against a sequence-level model.
module tb_flt_vector_stream_gen;

    localparam logic [31:0] SEED_A = 32'h1215_3524;
    localparam logic [31:0] SEED_B = 32'h8937_5212;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  vec_count;
    logic        loop_mode;
    logic        stop;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [15:0] pass_cnt;

    flt_vector_stream_gen #(
        .EXP_W (8),
        .MAN_W (23),
        .IDX_W (5),
        .CNT_W (16),
        .SEED_A(SEED_A),
        .SEED_B(SEED_B)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .vec_count(vec_count),
        .loop_mode(loop_mode),
        .stop     (stop),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_idx  (out_idx),
        .out_last (out_last),
        .busy     (busy),
        .done     (done),
        .pass_cnt (pass_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] spec [8];

    typedef struct {
        int cnt;
        bit loop;
        int stop_at;   // transfer number during which stop is driven; -1 = never
        bit rnd;       // random ready and stray start pulses
        int exp_xf;
        int exp_pass;
    } run_t;

    run_t runs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_ref(input logic [31:0] seed, input int n);
        logic [31:0] l;
        l = seed;
        for (int k = 0; k < n; k++) begin
            if (l[0]) l = (l >> 1) ^ 32'h8020_0003;
            else      l = l >> 1;
        end
        return l;
    endfunction

    function automatic logic [31:0] exp_a(input int idx);
        return (idx < 8) ? spec[idx] : lfsr_ref(SEED_A, idx - 8);
    endfunction

    function automatic logic [31:0] exp_b(input int idx);
        return (idx < 8) ? spec[(idx + 3) % 8] : lfsr_ref(SEED_B, idx - 8);
    endfunction

    task automatic do_run(input run_t r);
        int          xf;
        int          eff;
        int          idx;
        bit          seen_done;
        logic        rdy;
        logic        pv;
        logic        pr;
        logic [31:0] pa;
        logic [31:0] pb;
        logic [4:0]  pi;
        eff = (r.cnt > 32) ? 32 : r.cnt;
        start     = 1'b1;
        vec_count = 6'(r.cnt);
        loop_mode = r.loop;
        step();
        start = 1'b0;
        xf = 0;
        pv = 1'b0;
        pr = 1'b0;
        pa = '0;
        pb = '0;
        pi = '0;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            chk("valid_in_run", out_valid, 1);
            chk("busy_in_run", busy, 1);
            if (pv && !pr) begin
                chk("hold_a", out_a, pa);
                chk("hold_b", out_b, pb);
                chk("hold_idx", out_idx, pi);
            end
            rdy  = r.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stop = (xf == r.stop_at);
            if (r.rnd) begin
                start     = ($urandom_range(0, 3) == 0);
                vec_count = 6'($urandom_range(0, 63));
            end
            out_ready = rdy;
            if (out_valid && rdy) begin
                idx = (eff > 0) ? xf % eff : 0;
                chk("vec_a", out_a, exp_a(idx));
                chk("vec_b", out_b, exp_b(idx));
                chk("vec_idx", out_idx, idx);
                chk("vec_last", out_last, (idx == eff - 1));
                xf++;
            end
            pv = out_valid;
            pr = rdy;
            pa = out_a;
            pb = out_b;
            pi = out_idx;
            step();
        end
        start     = 1'b0;
        stop      = 1'b0;
        out_ready = 1'b0;
        chk("done_seen", seen_done, 1);
        chk("xfer_count", xf, r.exp_xf);
        chk("pass_cnt_at_done", pass_cnt, r.exp_pass);
        chk("valid_at_done", out_valid, 0);
        chk("busy_at_done", busy, 0);
        step();
        chk("done_one_cycle", done, 0);
        chk("pass_cnt_hold", pass_cnt, r.exp_pass);
        chk("idle_not_busy", busy, 0);
        step();
    endtask

    initial begin
        spec[0] = 32'h0000_0000;
        spec[1] = 32'h8000_0000;
        spec[2] = 32'h7F80_0000;
        spec[3] = 32'hFF80_0000;
        spec[4] = 32'h7FC0_0000;
        spec[5] = 32'h0080_0000;
        spec[6] = 32'h7F7F_FFFF;
        spec[7] = 32'h0000_0001;

        runs[0]  = '{cnt: 3,  loop: 0, stop_at: -1, rnd: 0, exp_xf: 3,  exp_pass: 1};
        runs[1]  = '{cnt: 10, loop: 0, stop_at: -1, rnd: 1, exp_xf: 10, exp_pass: 1};
        runs[2]  = '{cnt: 20, loop: 0, stop_at: -1, rnd: 1, exp_xf: 20, exp_pass: 1};
        runs[3]  = '{cnt: 20, loop: 0, stop_at: -1, rnd: 1, exp_xf: 20, exp_pass: 1};
        runs[4]  = '{cnt: 9,  loop: 1, stop_at: 22, rnd: 1, exp_xf: 23, exp_pass: 2};
        runs[5]  = '{cnt: 0,  loop: 0, stop_at: -1, rnd: 0, exp_xf: 0,  exp_pass: 0};
        runs[6]  = '{cnt: 63, loop: 0, stop_at: -1, rnd: 1, exp_xf: 32, exp_pass: 1};
        runs[7]  = '{cnt: 1,  loop: 0, stop_at: -1, rnd: 0, exp_xf: 1,  exp_pass: 1};
        runs[8]  = '{cnt: 10, loop: 1, stop_at: 25, rnd: 1, exp_xf: 26, exp_pass: 2};
        runs[9]  = '{cnt: 4,  loop: 1, stop_at: 11, rnd: 0, exp_xf: 12, exp_pass: 3};
        runs[10] = '{cnt: 0,  loop: 1, stop_at: -1, rnd: 0, exp_xf: 0,  exp_pass: 0};

        rst       = 1'b1;
        start     = 1'b0;
        vec_count = '0;
        loop_mode = 1'b0;
        stop      = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_a", out_a, 0);
        chk("rst_b", out_b, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 11; i++) begin
            do_run(runs[i]);
        end

        // Reset in the middle of a run: abort with no done pulse.
        start     = 1'b1;
        vec_count = 6'd10;
        loop_mode = 1'b0;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("midrun_valid_before_rst", out_valid, 1);
        chk("midrun_idx_before_rst", out_idx, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun_valid_after_rst", out_valid, 0);
        chk("midrun_busy_after_rst", busy, 0);
        chk("midrun_done_after_rst", done, 0);
        chk("midrun_a_after_rst", out_a, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("midrun_no_done", done, 0);
            chk("midrun_stays_idle", out_valid, 0);
        end
        out_ready = 1'b0;

        // Generator must be usable again after the abort.
        do_run(runs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
